// File: rtl/hazard_alarm_annunciator_if.sv
// rtl/hazard_alarm_annunciator_if.sv - hazard code inputs and panel lamp/buzzer outputs
interface hazard_alarm_annunciator_if;
    logic       red_in;
    logic       yellow_in;
    logic       green_in;
    logic       ack;
    logic       lamp_red;
    logic       lamp_yellow;
    logic       lamp_green;
    logic       buzzer;
    logic [1:0] alarm_level;
    logic       fault;

    modport master (
        output red_in, yellow_in, green_in, ack,
        input  lamp_red, lamp_yellow, lamp_green, buzzer, alarm_level, fault
    );

    modport slave (
        input  red_in, yellow_in, green_in, ack,
        output lamp_red, lamp_yellow, lamp_green, buzzer, alarm_level, fault
    );
endinterface

// File: rtl/hazard_alarm_annunciator.sv
// rtl/hazard_alarm_annunciator.sv - synchronise, debounce and latch hazard codes into lamps and buzzer
module hazard_alarm_annunciator #(
    parameter int DEBOUNCE_CYC = 4,
    parameter int BLINK_HALF   = 8
) (
    input  logic                         clk,
    input  logic                         rst_n,
    hazard_alarm_annunciator_if.slave    bus
);
    localparam int DW = $clog2(DEBOUNCE_CYC + 1);
    localparam int BW = $clog2(BLINK_HALF + 1);

    typedef enum logic [2:0] {
        S_SAFE, S_CAUTION, S_DANGER, S_DANGER_ACK, S_FAULT
    } state_t;

    logic [3:0]    r_sync1, r_sync2;
    logic [2:0]    r_cand, r_acc;
    logic [DW-1:0] r_db_cnt, w_db_cnt_next;
    logic          r_ack_d, r_ack_edge;
    state_t        r_state, w_state_next;
    logic [BW-1:0] r_blink_cnt, w_blink_cnt_next;
    logic          r_blink_on, w_blink_on_next;
    logic          r_lamp_red, r_lamp_yellow, r_lamp_green, r_buzzer, r_fault;
    logic [1:0]    r_level;
    logic          w_lamp_red, w_lamp_yellow, w_lamp_green, w_buzzer;
    logic [1:0]    w_level;
    logic          w_red, w_yel, w_grn, w_inv, w_blinking;

    // Synchroniser bits: {ack, red, yellow, green}
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= 4'b0001;
            r_sync2 <= 4'b0001;
        end else begin
            r_sync1 <= {bus.ack, bus.red_in, bus.yellow_in, bus.green_in};
            r_sync2 <= r_sync1;
        end
    end

    always_comb begin
        if (r_sync2[2:0] != r_cand)
            w_db_cnt_next = DW'(1);
        else if (r_db_cnt == DW'(DEBOUNCE_CYC))
            w_db_cnt_next = r_db_cnt;
        else
            w_db_cnt_next = r_db_cnt + DW'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cand     <= 3'b001;
            r_acc      <= 3'b001;
            r_db_cnt   <= '0;
            r_ack_d    <= 1'b0;
            r_ack_edge <= 1'b0;
        end else begin
            r_cand     <= r_sync2[2:0];
            r_db_cnt   <= w_db_cnt_next;
            if (w_db_cnt_next == DW'(DEBOUNCE_CYC))
                r_acc <= r_sync2[2:0];
            r_ack_d    <= r_sync2[3];
            r_ack_edge <= r_sync2[3] & ~r_ack_d;
        end
    end

    assign w_red = (r_acc == 3'b100);
    assign w_yel = (r_acc == 3'b010);
    assign w_grn = (r_acc == 3'b001);
    assign w_inv = !(w_red || w_yel || w_grn);

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_SAFE: begin
                if (w_yel)      w_state_next = S_CAUTION;
                else if (w_red) w_state_next = S_DANGER;
                else if (w_inv) w_state_next = S_FAULT;
            end
            S_CAUTION: begin
                if (w_grn)      w_state_next = S_SAFE;
                else if (w_red) w_state_next = S_DANGER;
                else if (w_inv) w_state_next = S_FAULT;
            end
            // Latched until the operator acknowledges; the live code only picks the exit.
            S_DANGER: begin
                if (r_ack_edge) begin
                    if (w_red)      w_state_next = S_DANGER_ACK;
                    else if (w_yel) w_state_next = S_CAUTION;
                    else if (w_grn) w_state_next = S_SAFE;
                    else            w_state_next = S_FAULT;
                end
            end
            S_DANGER_ACK: begin
                if (w_yel)      w_state_next = S_CAUTION;
                else if (w_grn) w_state_next = S_SAFE;
                else if (w_inv) w_state_next = S_FAULT;
            end
            S_FAULT: begin
                if (w_red)      w_state_next = S_DANGER;
                else if (w_yel) w_state_next = S_CAUTION;
                else if (w_grn) w_state_next = S_SAFE;
            end
            default: w_state_next = S_SAFE;
        endcase

        w_blinking       = (w_state_next == S_DANGER) || (w_state_next == S_FAULT);
        w_blink_cnt_next = '0;
        w_blink_on_next  = 1'b1;
        if (w_blinking && (w_state_next == r_state)) begin
            if (r_blink_cnt == BW'(BLINK_HALF - 1)) begin
                w_blink_cnt_next = '0;
                w_blink_on_next  = ~r_blink_on;
            end else begin
                w_blink_cnt_next = r_blink_cnt + BW'(1);
                w_blink_on_next  = r_blink_on;
            end
        end

        w_lamp_red    = 1'b0;
        w_lamp_yellow = 1'b0;
        w_lamp_green  = 1'b0;
        w_buzzer      = 1'b0;
        w_level       = 2'd0;
        case (w_state_next)
            S_SAFE:       w_lamp_green = 1'b1;
            S_CAUTION: begin
                w_lamp_yellow = 1'b1;
                w_level       = 2'd1;
            end
            S_DANGER: begin
                w_lamp_red = w_blink_on_next;
                w_buzzer   = 1'b1;
                w_level    = 2'd2;
            end
            S_DANGER_ACK: begin
                w_lamp_red = 1'b1;
                w_level    = 2'd2;
            end
            S_FAULT: begin
                w_lamp_yellow = w_blink_on_next;
                w_level       = 2'd3;
            end
            default: w_lamp_green = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_SAFE;
            r_blink_cnt   <= '0;
            r_blink_on    <= 1'b1;
            r_lamp_red    <= 1'b0;
            r_lamp_yellow <= 1'b0;
            r_lamp_green  <= 1'b1;
            r_buzzer      <= 1'b0;
            r_level       <= 2'd0;
            r_fault       <= 1'b0;
        end else begin
            r_state       <= w_state_next;
            r_blink_cnt   <= w_blink_cnt_next;
            r_blink_on    <= w_blink_on_next;
            r_lamp_red    <= w_lamp_red;
            r_lamp_yellow <= w_lamp_yellow;
            r_lamp_green  <= w_lamp_green;
            r_buzzer      <= w_buzzer;
            r_level       <= w_level;
            r_fault       <= w_inv;
        end
    end

    assign bus.lamp_red    = r_lamp_red;
    assign bus.lamp_yellow = r_lamp_yellow;
    assign bus.lamp_green  = r_lamp_green;
    assign bus.buzzer      = r_buzzer;
    assign bus.alarm_level = r_level;
    assign bus.fault       = r_fault;
endmodule

// File: tb/tb_hazard_alarm_annunciator.sv
// tb/tb_hazard_alarm_annunciator.sv - scoreboard bench for hazard_alarm_annunciator
module tb_hazard_alarm_annunciator;
    logic clk = 1'b0;
    logic rst_n;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    hazard_alarm_annunciator_if bus();

    hazard_alarm_annunciator #(.DEBOUNCE_CYC(4), .BLINK_HALF(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // {lamp_red, lamp_yellow, lamp_green, buzzer, alarm_level[1:0], fault}
    localparam logic [6:0] SAFE    = 7'b0010_00_0;
    localparam logic [6:0] CAUTION = 7'b0100_01_0;
    localparam logic [6:0] DACK    = 7'b1000_10_0;

    typedef struct {
        int         cyc;
        logic [6:0] v;
        string      nm;
    } exp_t;

    exp_t q[$];
    exp_t e_mon;
    logic [6:0] obs;

    function automatic logic [6:0] dng(int c, int entry);
        logic on;
        on = (((c - entry) / 8) % 2) == 0;
        return {on, 3'b001, 2'b10, 1'b0};
    endfunction

    function automatic logic [6:0] flt(int c, int entry);
        logic on;
        on = (((c - entry) / 8) % 2) == 0;
        return {1'b0, on, 2'b00, 2'b11, 1'b1};
    endfunction

    task automatic push(input int c, input logic [6:0] v, input string nm);
        exp_t e;
        e.cyc = c;
        e.v   = v;
        e.nm  = nm;
        q.push_back(e);
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic set_code(input logic [2:0] c);
        {bus.red_in, bus.yellow_in, bus.green_in} = c;
    endtask

    always @(negedge clk) begin
        obs = {bus.lamp_red, bus.lamp_yellow, bus.lamp_green, bus.buzzer, bus.alarm_level, bus.fault};
        while (q.size() > 0 && q[0].cyc <= cyc) begin
            e_mon = q.pop_front();
            checks++;
            if (e_mon.cyc != cyc) begin
                errors++;
                $display("FAIL %s: entry for cycle %0d reached monitor at cycle %0d", e_mon.nm, e_mon.cyc, cyc);
            end else if (obs !== e_mon.v) begin
                errors++;
                $display("FAIL %s cycle %0d: got %b expected %b", e_mon.nm, cyc, obs, e_mon.v);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int k, e, f;
        rst_n   = 1'b0;
        bus.ack = 1'b0;
        set_code(3'b001);
        step(1);

        k = cyc;
        for (int c = k; c < k + 3; c++) push(c, SAFE, "reset_state");
        step(3);
        rst_n = 1'b1;

        k = cyc;
        for (int c = k; c < k + 10; c++) push(c, SAFE, "t1_safe_hold");
        step(10);

        k = cyc;
        set_code(3'b100);
        for (int c = k; c < k + 7; c++) push(c, SAFE, "t2_latency");
        e = k + 7;
        for (int c = e; c < e + 20; c++) push(c, dng(c, e), "t2_danger_blink");
        step(27);

        k = cyc;
        set_code(3'b001);
        for (int c = k; c < k + 12; c++) push(c, dng(c, e), "t3_danger_latched");
        step(12);

        k = cyc;
        bus.ack = 1'b1;
        for (int c = k; c < k + 4; c++) push(c, dng(c, e), "t3_ack_wait");
        for (int c = k + 4; c < k + 8; c++) push(c, SAFE, "t3_ack_safe");
        step(2);
        bus.ack = 1'b0;
        step(6);

        k = cyc;
        set_code(3'b100);
        for (int c = k; c < k + 7; c++) push(c, SAFE, "t4_latency");
        e = k + 7;
        for (int c = e; c < e + 3; c++) push(c, dng(c, e), "t4_danger");
        step(10);

        k = cyc;
        bus.ack = 1'b1;
        for (int c = k; c < k + 4; c++) push(c, dng(c, e), "t4_ack_wait");
        for (int c = k + 4; c < k + 28; c++) push(c, DACK, "t4_danger_ack");
        step(20);
        bus.ack = 1'b0;
        step(8);

        k = cyc;
        set_code(3'b010);
        for (int c = k; c < k + 7; c++) push(c, DACK, "t4_ack_hold");
        for (int c = k + 7; c < k + 10; c++) push(c, CAUTION, "t4_caution");
        step(10);

        k = cyc;
        set_code(3'b001);
        for (int c = k; c < k + 7; c++) push(c, CAUTION, "t5_caution_hold");
        for (int c = k + 7; c < k + 10; c++) push(c, SAFE, "t5_safe");
        step(10);

        k = cyc;
        set_code(3'b010);
        for (int c = k; c < k + 16; c++) push(c, SAFE, "t5_glitch");
        step(3);
        set_code(3'b001);
        step(13);

        k = cyc;
        set_code(3'b110);
        for (int c = k; c < k + 7; c++) push(c, SAFE, "t5_fault_latency");
        f = k + 7;
        for (int c = f; c < f + 18; c++) push(c, flt(c, f), "t5_fault_blink");
        step(25);

        k = cyc;
        set_code(3'b001);
        for (int c = k; c < k + 7; c++) push(c, flt(c, f), "t5_fault_hold");
        for (int c = k + 7; c < k + 10; c++) push(c, SAFE, "t5_recover");
        step(10);

        k = cyc;
        set_code(3'b100);
        for (int c = k; c < k + 7; c++) push(c, SAFE, "t6_latency");
        e = k + 7;
        for (int c = e; c < e + 5; c++) push(c, dng(c, e), "t6_danger");
        step(12);

        k = cyc;
        rst_n = 1'b0;
        for (int c = k; c < k + 3; c++) push(c, SAFE, "t6_async_reset");
        step(3);
        rst_n = 1'b1;

        k = cyc;
        for (int c = k; c < k + 7; c++) push(c, SAFE, "t6_relatency");
        e = k + 7;
        for (int c = e; c < e + 6; c++) push(c, dng(c, e), "t6_reenter");
        step(13);

        step(2);
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
